// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// stopwatch_ctrl
//
// Control block for a two-button stopwatch. Each raw button is synchronised,
// debounced and edge-detected into a single press event. A four-state FSM
// (IDLE / RUN / PAUSE / LAP) reacts to those events. It drives a prescaler
// that emits a one-cycle TICK every TICK_DIV system clocks while the watch
// is running. It also drives the lap counter and the datapath clear pulse.
//
// Parameters
//   TICK_DIV   system clock cycles per stopwatch tick (>= 2)
//   DB_CYCLES  consecutive stable cycles needed to accept a new button level
//
// Ports
//   CLK             in   system clock, rising edge
//   RESET_N         in   asynchronous active-low reset
//   BTN_START_STOP  in   raw start/stop button, active-high, asynchronous
//   BTN_LAP_RESET   in   raw lap/reset button, active-high, asynchronous
//   TICK            out  one-cycle count enable for the datapath
//   RUNNING         out  high in RUN and LAP
//   SW_CLEAR        out  one-cycle clear pulse after PAUSE -> IDLE
//   LAP_HOLD        out  high while in LAP (display frozen)
//   STATE           out  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
//   LAP_COUNT       out  laps taken since the last clear, saturating at 15
// ============================================================================
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 100,
    parameter int DB_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       BTN_START_STOP,
    input  logic       BTN_LAP_RESET,
    output logic       TICK,
    output logic       RUNNING,
    output logic       SW_CLEAR,
    output logic       LAP_HOLD,
    output logic [1:0] STATE,
    output logic [3:0] LAP_COUNT
);

    localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam int PRE_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Button front end: bit 0 = start/stop, bit 1 = lap/reset
    // ------------------------------------------------------------------
    logic [1:0]       btn_raw;
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       db_level;
    logic [1:0]       db_level_q;
    logic [CNT_W-1:0] db_cnt [2];
    logic [1:0]       press_ev;

    assign btn_raw = {BTN_LAP_RESET, BTN_START_STOP};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: the debounced levels clear to 0 on reset. A button still
            // held when reset releases therefore shows a fresh 0->1 edge and
            // counts as a new press.
            sync_a     <= '0;
            sync_b     <= '0;
            db_level   <= '0;
            db_level_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make each flop sample the value
            // its source held before this edge. That is what turns sync_a and
            // sync_b into two real pipeline stages.
            sync_a     <= btn_raw;
            sync_b     <= sync_a;
            db_level_q <= db_level;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync_b[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // The debounced level rose on the previous edge.
    assign press_ev = db_level & ~db_level_q;

    // ------------------------------------------------------------------
    // FSM, prescaler, lap counter
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    logic [3:0]       lap_cnt_q;
    logic [3:0]       lap_cnt_d;
    logic             tick_q;
    logic             tick_d;
    logic             sw_clear_q;
    logic             sw_clear_d;
    logic             running_q;
    logic             running_d;
    logic             lap_hold_q;
    logic             lap_hold_d;
    logic             run_now;
    logic             run_next;

    always_comb begin
        // NOTE: every signal gets a default before any branch. A path that
        // leaves one unassigned would otherwise infer a latch.
        state_d    = state_q;
        presc_d    = presc_q;
        lap_cnt_d  = lap_cnt_q;
        tick_d     = 1'b0;
        sw_clear_d = 1'b0;

        // Start/stop wins when both events arrive in the same cycle.
        unique case (state_q)
            IDLE:    if (press_ev[0]) state_d = RUN;
            RUN:     if (press_ev[0]) state_d = PAUSE;
                     else if (press_ev[1]) state_d = LAP;
            PAUSE:   if (press_ev[0]) state_d = RUN;
                     else if (press_ev[1]) state_d = IDLE;
            LAP:     if (press_ev[0]) state_d = PAUSE;
                     else if (press_ev[1]) state_d = RUN;
            default: state_d = IDLE;
        endcase

        run_now  = (state_q == RUN) || (state_q == LAP);
        run_next = (state_d == RUN) || (state_d == LAP);

        // The prescaler keeps counting through the edge on which a stop
        // lands. It only wraps, and only ticks, if the watch stays running.
        // When a stop arrives at the last count, the prescaler parks there,
        // and the tick fires on the first running edge after the restart.
        if (run_now) begin
            if (presc_q != PRE_LAST) begin
                presc_d = presc_q + PRE_W'(1);
            end else if (run_next) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end
        end
        if (state_d == IDLE) begin
            presc_d = '0;
        end

        if (state_q == RUN && state_d == LAP && lap_cnt_q != 4'd15) begin
            lap_cnt_d = lap_cnt_q + 4'd1;
        end
        if (state_q == PAUSE && state_d == IDLE) begin
            lap_cnt_d  = '0;
            sw_clear_d = 1'b1;
        end

        running_d  = run_next;
        lap_hold_d = (state_d == LAP);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            lap_cnt_q  <= '0;
            tick_q     <= 1'b0;
            sw_clear_q <= 1'b0;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            lap_cnt_q  <= lap_cnt_d;
            tick_q     <= tick_d;
            sw_clear_q <= sw_clear_d;
            running_q  <= running_d;
            lap_hold_q <= lap_hold_d;
        end
    end

    assign STATE     = state_q;
    assign LAP_COUNT = lap_cnt_q;
    assign TICK      = tick_q;
    assign SW_CLEAR  = sw_clear_q;
    assign RUNNING   = running_q;
    assign LAP_HOLD  = lap_hold_q;

endmodule
